// File: rtl/spi_motor_rx_if.sv
// SPI slave pins plus the two motor speed words, grouped for the spi_motor_rx port list.
interface spi_motor_rx_if;
  logic       sck;
  logic       sdi;
  logic       sdo;
  logic [7:0] motor1;
  logic [7:0] motor2;

  modport master (output sck, sdi, input sdo, motor1, motor2);
  modport slave  (input sck, sdi, output sdo, motor1, motor2);
endinterface

// File: rtl/spi_motor_rx.sv
// Oversampled mode-0 SPI slave: 16-bit frames -> motor1/motor2, previous frame echoed on sdo.
// Optional idle-timeout resync of partial frames: define SPI_RESYNC_EN.
module spi_motor_rx #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  spi_motor_rx_if.slave  bus
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (IDLE_TIMEOUT < 1) begin : g_chk_idle
    $error("IDLE_TIMEOUT must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sck_sync, sdi_sync;
  logic                   sck_d;
  logic                   sck_s, sdi_s, rise, fall;
  logic [15:0]            shreg, shift_nxt, tx;
  logic [3:0]             bitcnt;
  logic [7:0]             motor1_q, motor2_q;
  logic                   idle_hit;

  // Synchronizers are left unreset so a reset while sck is high cannot fake a rise.
  always_ff @(posedge clk) begin
    sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
    sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
    sck_d    <= sck_s;
  end

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign rise      = sck_s & ~sck_d;
  assign fall      = ~sck_s & sck_d;
  assign shift_nxt = {shreg[14:0], sdi_s};

`ifdef SPI_RESYNC_EN
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  logic [IW-1:0] idle;

  always_ff @(posedge clk) begin
    if (reset)                           idle <= '0;
    else if (rise || fall)               idle <= '0;
    else if (idle != IW'(IDLE_TIMEOUT))  idle <= idle + 1'b1;
  end

  assign idle_hit = (idle == IW'(IDLE_TIMEOUT)) && (bitcnt != 4'd0);
`else
  assign idle_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      bitcnt   <= '0;
      motor1_q <= '0;
      motor2_q <= '0;
    end else if (rise) begin
      shreg  <= shift_nxt;
      bitcnt <= bitcnt + 4'd1;
      if (bitcnt == 4'd15) begin
        motor1_q <= shift_nxt[15:8];
        motor2_q <= shift_nxt[7:0];
      end
    end else if (idle_hit) begin
      shreg  <= '0;
      bitcnt <= '0;
    end
  end

  // The fall right after a frame completes must not shift, so bit 15 of the
  // new TX word is still on sdo for the first rise of the next frame.
  always_ff @(posedge clk) begin
    if (reset)                             tx <= '0;
    else if (rise && bitcnt == 4'd15)      tx <= shift_nxt;
    else if (fall && bitcnt != 4'd0)       tx <= {tx[14:0], 1'b0};
  end

  assign bus.sdo    = tx[15];
  assign bus.motor1 = motor1_q;
  assign bus.motor2 = motor2_q;

endmodule

// File: tb/tb_spi_motor_rx.sv
// Directed bench for spi_motor_rx: frames driven bit by bit, expected words via a scoreboard queue.
module tb_spi_motor_rx;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset;
  spi_motor_rx_if bus();

  spi_motor_rx #(.SYNC_STAGES(SYNC), .IDLE_TIMEOUT(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rb;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // sdi set mid low phase; sdo sampled just before the rise, as the host would
  task automatic send_bit(input logic b);
    bus.sdi = b;
    tick(1);
    rb = {rb[14:0], bus.sdo};
    bus.sck = 1'b1;
    tick(4);
    bus.sck = 1'b0;
    tick(3);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 15; i > 15 - n; i--) send_bit(v[i]);
  endtask

  task automatic check_motors(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {bus.motor1, bus.motor2}, e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] held;
    bus.sck = 1'b0;
    bus.sdi = 1'b0;
    reset   = 1'b1;
    rb      = '0;
    tick(5);
    reset = 1'b0;
    tick(2);

    chk("reset_motors", {bus.motor1, bus.motor2}, 16'h0000);
    chk("reset_sdo", {15'd0, bus.sdo}, 16'h0000);

    // 0xAA55: outputs stay zero until the 16th rise
    exp_q.push_back(16'hAA55);
    send_bits(16'hAA55, 15);
    chk("aa55_before_16th", {bus.motor1, bus.motor2}, 16'h0000);
    send_bit(1'b1);
    check_motors("aa55_frame");
    chk("aa55_readback", rb, 16'h0000);

    // back-to-back 0x1234; sdo echoes 0xAA55 during it
    exp_q.push_back(16'h1234);
    send_bits(16'h1234, 15);
    chk("1234_before_32nd", {bus.motor1, bus.motor2}, 16'hAA55);
    send_bit(1'b0);
    check_motors("1234_frame");
    chk("1234_readback", rb, 16'hAA55);

    // sck idle while sdi toggles: nothing moves
    for (int i = 0; i < 1000; i++) begin
      bus.sdi = ~bus.sdi;
      tick(1);
    end
    chk("idle_motors", {bus.motor1, bus.motor2}, 16'h1234);
    chk("idle_sdo", {15'd0, bus.sdo}, 16'h0000);

    // partial frame then reset: the 0xFF bits must not leak into 0x0F0F
    send_bits(16'hFF00, 8);
    chk("partial_no_update", {bus.motor1, bus.motor2}, 16'h1234);
    do_reset();
    tick(2);
    chk("midreset_motors", {bus.motor1, bus.motor2}, 16'h0000);
    chk("midreset_sdo", {15'd0, bus.sdo}, 16'h0000);
    exp_q.push_back(16'h0F0F);
    send_bits(16'h0F0F, 16);
    check_motors("0f0f_frame");
    chk("0f0f_readback", rb, 16'h0000);

    // bit-order extremes
    exp_q.push_back(16'h0001);
    send_bits(16'h0001, 16);
    check_motors("0001_frame");
    chk("0001_readback", rb, 16'h0F0F);
    exp_q.push_back(16'h8000);
    send_bits(16'h8000, 16);
    check_motors("8000_frame");
    chk("8000_readback", rb, 16'h0001);

    // 8 stray bits, long idle, then 0xC33C
    send_bits(16'hFF00, 8);
    tick(1100);
`ifdef SPI_RESYNC_EN
    exp_q.push_back(16'hC33C);
    send_bits(16'hC33C, 16);
    check_motors("resync_c33c");
`else
    held = {bus.motor1, bus.motor2};
    chk("misalign_hold", held, 16'h8000);
    exp_q.push_back(16'hFFC3);
    send_bits(16'hC33C, 8);
    check_motors("misalign_first16");
    send_bits(16'h3C00, 8);
    chk("misalign_partial_hold", {bus.motor1, bus.motor2}, 16'hFFC3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
